// File: rtl/snes_joy_autoread.sv
// snes_joy_autoread
// Auto-joypad sequencer for two SNES controller ports. A start pulse
// produces one strobe and sixteen clock pulses on the shared serial lines.
// Both 16-bit results are then captured on the same edge. Between reads
// the serial lines are handed to the CPU's manual strobe/clock.
module snes_joy_autoread #(
  parameter int STRB_CYC = 256,
  parameter int HALF_CYC = 128,
  parameter int NBITS    = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             enable,
  input  logic             start,
  output logic             busy,
  output logic             done,
  input  logic             cpu_strb,
  input  logic             cpu_clk,
  output logic             joy_strb,
  output logic             joy_clk,
  input  logic             joy1_di,
  input  logic             joy2_di,
  output logic [NBITS-1:0] joy1_data,
  output logic [NBITS-1:0] joy2_data
);

  // Phase counter is sized for the longer of the two phase lengths.
  localparam int MAXC = (STRB_CYC > HALF_CYC) ? STRB_CYC : HALF_CYC;
  localparam int CW   = (MAXC < 2) ? 1 : $clog2(MAXC);

  localparam logic [CW-1:0] STRB_LAST = CW'(STRB_CYC - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CYC - 1);
  localparam logic [3:0]    LAST_BIT  = 4'(NBITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STRB,
    ST_HIGH,
    ST_LOW
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cyc_q, cyc_d;
  logic [3:0]       n_q, n_d;
  logic [NBITS-1:0] sh1_q, sh1_d;
  logic [NBITS-1:0] sh2_q, sh2_d;
  logic [NBITS-1:0] data1_q, data1_d;
  logic [NBITS-1:0] data2_q, data2_d;
  logic             done_q, done_d;

  logic             sample;
  logic             finish;
  logic             fsm_strb;
  logic             fsm_clk;

  // State and datapath registers; reset aborts any read in progress.
  // NOTE: every flop here has a reset value, including the shift registers.
  // A mid-read reset then leaves no stale partial result behind.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      cyc_q   <= '0;
      n_q     <= '0;
      sh1_q   <= '0;
      sh2_q   <= '0;
      data1_q <= '0;
      data2_q <= '0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let all flops see pre-edge values.
      state_q <= state_d;
      cyc_q   <= cyc_d;
      n_q     <= n_d;
      sh1_q   <= sh1_d;
      sh2_q   <= sh2_d;
      data1_q <= data1_d;
      data2_q <= data2_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic: phase timing, bit counter, sample and finish strobes.
  always_comb begin
    // NOTE: defaults first so no path through the case leaves a latch.
    state_d = state_q;
    cyc_d   = cyc_q;
    n_d     = n_q;
    sample  = 1'b0;
    finish  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cyc_d = '0;
        n_d   = '0;
        // A start coinciding with done is dropped; a fresh request must follow.
        if (start && enable && !done_q) state_d = ST_STRB;
      end
      ST_STRB: begin
        if (cyc_q == STRB_LAST) begin
          cyc_d   = '0;
          n_d     = '0;
          state_d = ST_HIGH;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      ST_HIGH: begin
        if (cyc_q == HALF_LAST) begin
          cyc_d   = '0;
          sample  = 1'b1;
          state_d = ST_LOW;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      ST_LOW: begin
        if (cyc_q == HALF_LAST) begin
          cyc_d = '0;
          if (n_q == LAST_BIT) begin
            finish  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            n_d     = n_q + 1'b1;
            state_d = ST_HIGH;
          end
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Shift capture (first bit lands in bit 15) and atomic result update.
  always_comb begin
    sh1_d   = sh1_q;
    sh2_d   = sh2_q;
    data1_d = data1_q;
    data2_d = data2_q;
    done_d  = finish;
    if (state_q == ST_IDLE && state_d == ST_STRB) begin
      sh1_d = '0;
      sh2_d = '0;
    end
    if (sample) begin
      sh1_d[LAST_BIT - n_q] = ~joy1_di;
      sh2_d[LAST_BIT - n_q] = ~joy2_di;
    end
    if (finish) begin
      data1_d = sh1_q;
      data2_d = sh2_q;
    end
  end

  // Outputs: port waveform decoded from state, muxed with the CPU lines.
  always_comb begin
    busy      = (state_q != ST_IDLE);
    fsm_strb  = (state_q == ST_STRB);
    fsm_clk   = (state_q != ST_LOW);
    joy_strb  = busy ? fsm_strb : cpu_strb;
    joy_clk   = busy ? fsm_clk  : cpu_clk;
    done      = done_q;
    joy1_data = data1_q;
    joy2_data = data2_q;
  end

endmodule

// File: tb/tb_snes_joy_autoread.sv
// tb_snes_joy_autoread
// Directed sequence with randomized button values. A behavioural controller
// model drives the data lines. Expected waveforms come from cycle arithmetic.
// Expected results come from the buttons with their low nibble forced to zero.
module tb_snes_joy_autoread;

  localparam int STRB = 4;
  localparam int HALF = 2;
  localparam int RLEN = STRB + 32 * HALF;

  logic        clk = 1'b0;
  logic        resetn;
  logic        enable;
  logic        start;
  logic        cpu_strb;
  logic        cpu_clk;
  logic        joy1_di;
  logic        joy2_di;
  logic        busy;
  logic        done;
  logic        joy_strb;
  logic        joy_clk;
  logic [15:0] joy1_data;
  logic [15:0] joy2_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] btn1 = '0;
  logic [15:0] btn2 = '0;
  logic [15:0] exp1 = '0;
  logic [15:0] exp2 = '0;
  int          idx  = 16;

  snes_joy_autoread #(
    .STRB_CYC(STRB),
    .HALF_CYC(HALF),
    .NBITS   (16)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .enable   (enable),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .cpu_strb (cpu_strb),
    .cpu_clk  (cpu_clk),
    .joy_strb (joy_strb),
    .joy_clk  (joy_clk),
    .joy1_di  (joy1_di),
    .joy2_di  (joy2_di),
    .joy1_data(joy1_data),
    .joy2_data(joy2_data)
  );

  always #5 clk = ~clk;

  // Controller model: strobe reloads, each falling clock edge shifts one bit.
  always @(posedge joy_strb or negedge joy_clk) begin
    if (joy_strb) idx = 0;
    else          idx = idx + 1;
  end

  // Active-low serial data; the controller shifts zeros for the low nibble.
  always_comb begin
    logic [15:0] m1;
    logic [15:0] m2;
    m1 = btn1 & 16'hFFF0;
    m2 = btn2 & 16'hFFF0;
    if (idx >= 0 && idx < 16) begin
      joy1_di = ~m1[4'(15 - idx)];
      joy2_di = ~m2[4'(15 - idx)];
    end else begin
      joy1_di = 1'b0;
      joy2_di = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One full auto-read with per-cycle waveform and result checks.
  task automatic do_read(input logic [15:0] b1, input logic [15:0] b2,
                         input bit mid_start, input bit drop_en,
                         input bit wiggle_cpu, input bit start_on_done);
    int   falls;
    logic prev_clk;
    logic exp_clk;
    btn1 = b1;
    btn2 = b2;
    @(negedge clk);
    check("idle_clk_before", joy_clk, 1);
    check("idle_busy_before", busy, 0);
    start  = 1'b1;
    enable = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (drop_en) enable = 1'b0;
    falls    = 0;
    prev_clk = 1'b1;
    for (int k = 0; k < RLEN; k++) begin
      if (k > 0) @(negedge clk);
      exp_clk = (k < STRB) ? 1'b1 : ((((k - STRB) / HALF) % 2) == 0);
      check("busy_during", busy, 1);
      check("done_during", done, 0);
      check("strb_wave", joy_strb, (k < STRB) ? 1 : 0);
      check("clk_wave", joy_clk, exp_clk);
      check("data1_hold", joy1_data, exp1);
      check("data2_hold", joy2_data, exp2);
      if (prev_clk && !joy_clk) falls++;
      prev_clk = joy_clk;
      start = mid_start && (k == 10);
      if (wiggle_cpu) begin
        cpu_clk  = 1'($urandom);
        cpu_strb = 1'($urandom);
      end
    end
    start    = 1'b0;
    cpu_clk  = 1'b1;
    cpu_strb = 1'b0;
    @(negedge clk);
    exp1 = b1 & 16'hFFF0;
    exp2 = b2 & 16'hFFF0;
    check("falls_16", falls, 16);
    check("done_pulse", done, 1);
    check("busy_end", busy, 0);
    check("data1_result", joy1_data, exp1);
    check("data2_result", joy2_data, exp2);
    check("idle_clk_after", joy_clk, 1);
    check("idle_strb_after", joy_strb, 0);
    if (start_on_done) begin
      start  = 1'b1;
      enable = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    check("done_single", done, 0);
    check("no_restart", busy, 0);
    @(negedge clk);
    check("no_restart2", busy, 0);
    check("data1_stable", joy1_data, exp1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end

  initial begin
    resetn   = 1'b0;
    enable   = 1'b0;
    start    = 1'b0;
    cpu_strb = 1'b0;
    cpu_clk  = 1'b1;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_data1", joy1_data, 0);
    check("rst_data2", joy2_data, 0);
    check("rst_clk_mux", joy_clk, 1);
    cpu_clk = 1'b0;
    #1;
    check("rst_clk_follow", joy_clk, 0);
    cpu_clk = 1'b1;
    repeat (3) @(negedge clk);
    resetn = 1'b1;

    // Manual ownership while idle.
    for (int i = 0; i < 6; i++) begin
      cpu_strb = 1'($urandom);
      cpu_clk  = 1'($urandom);
      #1;
      check("manual_strb", joy_strb, cpu_strb);
      check("manual_clk", joy_clk, cpu_clk);
      @(negedge clk);
      check("manual_busy", busy, 0);
    end
    cpu_strb = 1'b0;
    cpu_clk  = 1'b1;

    // Start with enable low is dropped.
    @(negedge clk);
    start  = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("noen_busy", busy, 0);
      check("noen_strb", joy_strb, 0);
      @(negedge clk);
    end

    // Reference read with CPU lines toggling during busy.
    do_read(16'h8F31, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
    check("ref_result", joy1_data, 16'h8F30);
    // Back-to-back reads; the second also sees a start at cycle 10.
    do_read(16'hFFF0, 16'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
    do_read(16'h0010, 16'($urandom), 1'b1, 1'b0, 1'b0, 1'b0);
    // Enable dropped mid-read; start on the done cycle is ignored.
    do_read(16'($urandom), 16'($urandom), 1'b0, 1'b1, 1'b0, 1'b1);
    for (int r = 0; r < 3; r++)
      do_read(16'($urandom), 16'($urandom), 1'b0, 1'b0, 1'b1, 1'b0);

    // Reset during the LOW phase of bit 7.
    btn1 = 16'($urandom);
    btn2 = 16'($urandom);
    @(negedge clk);
    start  = 1'b1;
    enable = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (STRB + 7 * 2 * HALF + HALF) @(negedge clk);
    check("pre_rst_busy", busy, 1);
    check("pre_rst_low", joy_clk, 0);
    resetn  = 1'b0;
    cpu_clk = 1'b1;
    #1;
    exp1 = '0;
    exp2 = '0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_data1", joy1_data, 0);
    check("abort_data2", joy2_data, 0);
    check("abort_clk_follow", joy_clk, 1);
    cpu_clk = 1'b0;
    #1;
    check("abort_clk_follow0", joy_clk, 0);
    cpu_clk = 1'b1;
    @(negedge clk);
    check("abort_no_done", done, 0);
    resetn = 1'b1;
    do_read(16'($urandom), 16'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/snes_joy_autoread.md
Name: snes_joy_autoread

Overview:
- Sequences the SNES controller serial port (strobe, clock, active-low data) driven by the DualShock-to-SNES converter for two ports, mirroring the SNES auto-joypad read.
- On a start pulse (vblank with auto-read enabled), issues one strobe and 16 clock pulses, then captures both 16-bit results atomically.
- Between auto-reads it arbitrates the port to the CPU's manual strobe/clock (the $4016 path), so there is a single owner of the shared serial lines.

Parameters:
- STRB_CYC, 256, clk cycles joy_strb is held high (~12 us at 21.6 MHz); must be >=1
- HALF_CYC, 128, clk cycles per joy_clk high phase and per low phase; must be >=1
- NBITS, 16, bits shifted per port; fixed at 16 in this design

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- enable  in  1  auto-read enable; gates start only
- start  in  1  single-cycle request to begin an auto-read
- busy  out  1  high while the sequencer owns the port
- done  out  1  one-cycle pulse when results update
- cpu_strb  in  1  manual strobe, used when not busy
- cpu_clk  in  1  manual clock, used when not busy; idles high
- joy_strb  out  1  strobe to the controller serial port
- joy_clk  out  1  clock to the controller serial port; idles high; the controller shifts on its falling edge
- joy1_di  in  1  port 1 serial data, active-low
- joy2_di  in  1  port 2 serial data, active-low
- joy1_data  out  16  port 1 result: bit15=B, bit14=Y, …, bit4=R, bits3:0=0 from the controller
- joy2_data  out  16  port 2 result, same layout

Behaviour:
- Reset (async, resetn=0): state=IDLE, busy=0, done=0, joy1_data=joy2_data=0, internal shift registers and counters cleared. While in reset, joy_strb=cpu_strb and joy_clk=cpu_clk (muxed from the FSM's idle state).
- Port mux: busy=0 -> joy_strb=cpu_strb, joy_clk=cpu_clk. busy=1 -> both driven from FSM registers; CPU inputs are ignored.
- FSM states: IDLE, STRB, HIGH, LOW.
- IDLE: start=1 && enable=1 -> STRB on the next edge; busy=1 from the following cycle. start with enable=0 is dropped, not queued.
- STRB: joy_strb=1, joy_clk=1 for exactly STRB_CYC cycles -> HIGH, with bit counter n=0.
- HIGH: joy_strb=0, joy_clk=1 for HALF_CYC cycles.
  - On the last HIGH cycle, sample sh1[15-n]=~joy1_di and sh2[15-n]=~joy2_di, so the first sampled bit lands in bit 15.
  - Then -> LOW.
- LOW: joy_clk=0 for HALF_CYC cycles.
  - If n<15: n+=1 and -> HIGH.
  - If n==15: -> IDLE; on that same edge joy1_data<=sh1, joy2_data<=sh2, done=1 for one cycle, busy=0.
- Timing: total busy = STRB_CYC + 32*HALF_CYC cycles. Exactly 16 joy_clk falling edges per read; joy_clk ends high.
- Result registers change only on the done edge; reads during busy return the previous result.
- start while busy: ignored; no restart, no queueing.
- start on the same cycle as done: ignored. A new read requires start in a later cycle with busy=0.
- enable deasserted mid-read: the read completes normally.
- Reset mid-read: abort immediately; the port returns to CPU ownership; results clear to 0; no done pulse.
- Counters are sized for the largest parameter value. There is no wrap within a read: n is 4 bits, 0..15.

Test Plan:
- Params STRB_CYC=4, HALF_CYC=2. Model a controller with bits 0x8F31 (port 1) and 0x0000 (port 2), DI active-low. Pulse start with enable=1 -> busy high for 68 cycles, exactly 16 joy_clk falling edges, then done pulses once and joy1_data=0x8F30, joy2_data=0x0000. Lower nibble is 0 because the controller shifts zeros there.
- Waveform check on the same read: joy_strb high for exactly 4 cycles; each joy_clk high and low phase is 2 cycles; joy_clk is high in IDLE before and after the read.
- Manual ownership: busy=0, toggle cpu_strb and cpu_clk -> joy_strb/joy_clk follow the same cycle. During busy, toggling cpu_clk -> no effect on joy_clk.
- start with enable=0 -> no strobe, busy stays 0. start pulsed at cycle 10 of an active read -> a single read only, one done pulse.
- Two reads: first with buttons 0xFFF0, second with 0x0010 -> joy1_data holds 0xFFF0 throughout the second read until its done edge, then becomes 0x0010.
- Assert resetn=0 during the LOW phase of bit 7 -> busy=0 immediately, joy1_data=0, joy_clk follows cpu_clk. After release, a fresh start performs a full correct read.
